// File: rtl/dmem_bus_bridge.sv
// rtl/dmem_bus_bridge.sv - MEM-stage load/store to ready/valid word bus bridge
// Stalls the pipeline per access, returns lane-extracted, extended load data.
module dmem_bus_bridge #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       rsp_rdata,
  output logic              stall,
  output logic              access_err,
  output logic              timeout_err,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bus_valid_q, bus_valid_d;
  logic               bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
  logic [3:0]         bus_wstrb_q, bus_wstrb_d;
  logic [31:0]        bus_wdata_q, bus_wdata_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         lane_q, lane_d;
  logic [31:0]        rsp_q, rsp_d;
  logic               terr_q, terr_d;

  logic               req_present, req_illegal, misalign, bad_f3, timed_out;
  logic [31:0]        store_wdata, load_data;
  logic [3:0]         store_wstrb;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;

  assign req_present = req_rd | req_wr;
  assign timed_out   = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    misalign = 1'b0;
    bad_f3   = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: misalign = 1'b0;
      3'b001, 3'b101: misalign = req_addr[0];
      3'b010:         misalign = (req_addr[1:0] != 2'b00);
      default:        bad_f3   = 1'b1;
    endcase
    // Store wins over load, so an unsigned funct3 is illegal whenever req_wr is set.
    req_illegal = bad_f3 | misalign | (req_wr & req_funct3[2]);
  end

  always_comb begin
    store_wdata = req_wdata;
    store_wstrb = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        store_wdata = {4{req_wdata[7:0]}};
        store_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        store_wdata = {2{req_wdata[15:0]}};
        store_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_wdata = req_wdata;
        store_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    byte_sel = bus_rdata[7:0];
    case (lane_q)
      2'd0: byte_sel = bus_rdata[7:0];
      2'd1: byte_sel = bus_rdata[15:8];
      2'd2: byte_sel = bus_rdata[23:16];
      2'd3: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   load_data = {{24{~f3_q[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{~f3_q[2] & half_sel[15]}}, half_sel};
      default: load_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    rsp_d       = rsp_q;
    terr_d      = terr_q;
    stall       = 1'b0;
    access_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_present && req_illegal) begin
          access_err = 1'b1;
        end else if (req_present) begin
          stall       = 1'b1;
          state_d     = REQ;
          cnt_d       = '0;
          bus_valid_d = 1'b1;
          bus_we_d    = req_wr;
          bus_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          bus_wstrb_d = req_wr ? store_wstrb : 4'b0000;
          bus_wdata_d = req_wr ? store_wdata : 32'd0;
          f3_d        = req_funct3;
          lane_d      = req_addr[1:0];
        end
      end
      REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          state_d     = bus_we_q ? DONE : RESP;
        end else if (timed_out) begin
          bus_valid_d = 1'b0;
          terr_d      = 1'b1;
          rsp_d       = 32'd0;
          state_d     = DONE;
        end
      end
      RESP: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_rvalid) begin
          rsp_d   = load_data;
          state_d = DONE;
        end else if (timed_out) begin
          terr_d  = 1'b1;
          rsp_d   = 32'd0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= 4'b0000;
      bus_wdata_q <= 32'd0;
      f3_q        <= 3'b000;
      lane_q      <= 2'b00;
      rsp_q       <= 32'd0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      rsp_q       <= rsp_d;
      terr_q      <= terr_d;
    end
  end

  assign rsp_rdata   = rsp_q;
  assign timeout_err = terr_q;
  assign bus_valid   = bus_valid_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wstrb   = bus_wstrb_q;
  assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb/tb_dmem_bus_bridge.sv - directed scoreboard bench for dmem_bus_bridge
module tb_dmem_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_rd, req_wr;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic [31:0] rsp_rdata;
  logic        stall, access_err, timeout_err;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  always #5 clk = ~clk;

  dmem_bus_bridge #(.ADDR_W(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_rdata(rsp_rdata), .stall(stall), .access_err(access_err),
    .timeout_err(timeout_err), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic        ready_en     = 1'b1;
  logic        rvalid_en    = 1'b1;
  logic        force_rvalid = 1'b0;
  logic        rd_pend      = 1'b0;
  logic [31:0] slave_word   = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Slave acts shortly after the falling edge so it sees this cycle's bench drives.
  initial begin
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      #2;
      bus_rvalid = force_rvalid;
      if (!rst) begin
        rd_pend = 1'b0;
      end else if (rd_pend && rvalid_en) begin
        bus_rvalid = 1'b1;
        bus_rdata  = slave_word;
        rd_pend    = 1'b0;
      end
      bus_ready = ready_en;
      if (rst && bus_valid && bus_ready && !bus_we) rd_pend = 1'b1;
    end
  end

  function automatic exp_t model(input logic wr, input logic [31:0] addr,
                                 input logic [2:0] f3, input logic [31:0] wd,
                                 input logic [31:0] exp_rd);
    exp_t e;
    e.addr  = {addr[31:2], 2'b00};
    e.we    = wr;
    e.strb  = 4'b0000;
    e.wdata = 32'd0;
    e.rdata = exp_rd;
    if (wr) begin
      case (f3)
        3'b000: begin e.wdata = {4{wd[7:0]}};  e.strb = 4'(1 << addr[1:0]); end
        3'b001: begin e.wdata = {2{wd[15:0]}}; e.strb = addr[1] ? 4'b1100 : 4'b0011; end
        default: begin e.wdata = wd; e.strb = 4'b1111; end
      endcase
    end
    return e;
  endfunction

  task automatic access(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input logic [31:0] word,
                        input logic [31:0] exp_rd, input string tag,
                        input int exp_stall, output int valid_n);
    exp_t e;
    int   stall_n;
    bit   done;
    sb.push_back(model(wr, addr, f3, wd, exp_rd));
    slave_word = word;
    req_rd = ~wr; req_wr = wr; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    #1;
    chk({tag, "_stall_idle"}, {31'd0, stall}, 32'd1);
    stall_n = stall ? 1 : 0;
    valid_n = 0;
    done    = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (bus_valid) begin
        valid_n++;
        if (valid_n == 1) begin
          chk({tag, "_sb_nonempty"}, sb.size(), 1);
          if (sb.size() > 0) begin
            e = sb[0];
            chk({tag, "_addr"}, bus_addr, e.addr);
            chk({tag, "_we"}, {31'd0, bus_we}, {31'd0, e.we});
            chk({tag, "_wstrb"}, {28'd0, bus_wstrb}, {28'd0, e.strb});
            if (e.we) chk({tag, "_wdata"}, bus_wdata, e.wdata);
          end
        end
      end
      if (!stall) done = 1'b1;
      else stall_n++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!wr) chk({tag, "_rsp"}, rsp_rdata, e.rdata);
    end
    chk({tag, "_stall_cycles"}, stall_n, exp_stall);
    chk({tag, "_valid_done"}, {31'd0, bus_valid}, 32'd0);
    req_rd = 1'b0; req_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic illegal(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [2:0] f3, input string tag);
    req_rd = rd; req_wr = wr; req_addr = addr; req_funct3 = f3; req_wdata = 32'hFFFF_FFFF;
    #1;
    chk({tag, "_err"}, {31'd0, access_err}, 32'd1);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    @(negedge clk);
    chk({tag, "_no_valid"}, {31'd0, bus_valid}, 32'd0);
    req_rd = 1'b0; req_wr = 1'b0;
    #1;
    chk({tag, "_err_clear"}, {31'd0, access_err}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int vn;
    bit seen;
    rst = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
    req_addr = 32'd0; req_funct3 = 3'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_we", {31'd0, bus_we}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wstrb", {28'd0, bus_wstrb}, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rsp", rsp_rdata, 32'd0);
    chk("rst_aerr", {31'd0, access_err}, 32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    access(1'b1, 32'h100, 3'b010, 32'h1234_5678, 32'd0, 32'd0, "sw", 2, vn);
    access(1'b0, 32'h203, 3'b000, 32'd0, 32'h80FF_0000, 32'hFFFF_FF80, "lb", 3, vn);
    access(1'b0, 32'h203, 3'b100, 32'd0, 32'h80FF_0000, 32'h0000_0080, "lbu", 3, vn);
    access(1'b1, 32'h102, 3'b001, 32'h0000_ABCD, 32'd0, 32'd0, "sh", 2, vn);
    access(1'b1, 32'h101, 3'b000, 32'h0000_00A5, 32'd0, 32'd0, "sb", 2, vn);
    access(1'b0, 32'h202, 3'b001, 32'd0, 32'h80FF_0000, 32'hFFFF_80FF, "lh", 3, vn);
    access(1'b0, 32'h202, 3'b101, 32'd0, 32'h80FF_0000, 32'h0000_80FF, "lhu", 3, vn);
    access(1'b0, 32'h204, 3'b010, 32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "lw", 3, vn);
    chk("lw_valid_cycles", vn, 1);

    illegal(1'b1, 1'b0, 32'h102, 3'b010, "ill_lw");
    illegal(1'b1, 1'b0, 32'h203, 3'b001, "ill_lh");
    illegal(1'b1, 1'b0, 32'h100, 3'b011, "ill_f3");
    illegal(1'b0, 1'b1, 32'h100, 3'b100, "ill_sbu");
    illegal(1'b1, 1'b1, 32'h100, 3'b101, "ill_both");

    ready_en = 1'b0;
    access(1'b0, 32'h40, 3'b010, 32'd0, 32'h1111_1111, 32'd0, "tmo", 256, vn);
    chk("tmo_valid_cycles", vn, 255);
    chk("tmo_err", {31'd0, timeout_err}, 32'd1);
    ready_en = 1'b1;
    access(1'b1, 32'h8, 3'b010, 32'hCAFE_F00D, 32'd0, 32'd0, "sw2", 2, vn);
    chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);

    rvalid_en = 1'b0;
    req_rd = 1'b1; req_wr = 1'b0; req_addr = 32'h300; req_funct3 = 3'b010;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!bus_valid && stall) seen = 1'b1;
    end
    chk("mid_resp_reached", {31'd0, seen}, 32'd1);
    rst = 1'b0; req_rd = 1'b0;
    @(negedge clk);
    chk("mid_valid", {31'd0, bus_valid}, 32'd0);
    chk("mid_stall", {31'd0, stall}, 32'd0);
    chk("mid_addr", bus_addr, 32'd0);
    chk("mid_rsp", rsp_rdata, 32'd0);
    chk("mid_terr", {31'd0, timeout_err}, 32'd0);
    rst = 1'b1;
    force_rvalid = 1'b1;
    @(negedge clk);
    force_rvalid = 1'b0;
    chk("stray_valid", {31'd0, bus_valid}, 32'd0);
    chk("stray_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    chk("stray_rsp", rsp_rdata, 32'd0);
    chk("stray_idle", {31'd0, bus_valid | stall}, 32'd0);
    rvalid_en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
